// File: rtl/fp_multi.sv
// Iterative binary32 multiplier: shift-add mantissa product, RNE rounding,
// flush-to-zero underflow, fixed 26-cycle latency from sel to vld.
module fp_multi (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sel,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [31:0] result,
  output logic        vld,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM,
    PACK
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } spec_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state;
  spec_t              spec;
  logic [4:0]         cnt;
  logic [47:0]        acc;
  logic [23:0]        mcand;
  logic               sign;
  logic signed [9:0]  exp_r;
  logic [22:0]        mant_r;
  logic               guard;
  logic               sticky;

  logic [7:0]         e1;
  logic [7:0]         e2;
  logic               z1;
  logic               z2;
  logic               i1;
  logic               i2;
  logic               n1;
  logic               n2;
  logic [23:0]        m1;
  logic [23:0]        m2;
  logic signed [9:0]  exp_sum;
  spec_t              spec_in;

  logic               rnd_inc;
  logic [23:0]        rnd_sum;
  logic signed [9:0]  exp_fin;
  logic [22:0]        frac_fin;
  logic [31:0]        pack_res;

  function automatic logic [47:0] mac_step(
    input logic [47:0] a,
    input logic [23:0] mc
  );
    logic [24:0] s;
    s = {1'b0, a[47:24]} + (a[0] ? {1'b0, mc} : 25'd0);
    return {s, a[23:1]};
  endfunction

  assign e1 = data1[30:23];
  assign e2 = data2[30:23];
  assign z1 = (e1 == 8'h00);
  assign z2 = (e2 == 8'h00);
  assign i1 = (e1 == 8'hFF) && (data1[22:0] == 23'd0);
  assign i2 = (e2 == 8'hFF) && (data2[22:0] == 23'd0);
  assign n1 = (e1 == 8'hFF) && (data1[22:0] != 23'd0);
  assign n2 = (e2 == 8'hFF) && (data2[22:0] != 23'd0);
  assign m1 = z1 ? 24'd0 : {1'b1, data1[22:0]};
  assign m2 = z2 ? 24'd0 : {1'b1, data2[22:0]};
  assign exp_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;

  always_comb begin
    spec_in = SP_NONE;
    if (n1 || n2)
      spec_in = SP_NAN;
    else if ((i1 && z2) || (i2 && z1))
      spec_in = SP_NAN;
    else if (i1 || i2)
      spec_in = SP_INF;
    else if (z1 || z2)
      spec_in = SP_ZERO;
  end

  assign rnd_inc  = guard & (sticky | mant_r[0]);
  assign rnd_sum  = {1'b0, mant_r} + {23'd0, rnd_inc};
  assign exp_fin  = rnd_sum[23] ? exp_r + 10'sd1 : exp_r;
  assign frac_fin = rnd_sum[23] ? 23'd0 : rnd_sum[22:0];

  always_comb begin
    pack_res = {sign, exp_fin[7:0], frac_fin};
    unique case (spec)
      SP_NAN:  pack_res = QNAN;
      SP_INF:  pack_res = {sign, 8'hFF, 23'd0};
      SP_ZERO: pack_res = {sign, 31'd0};
      default: begin
        if (exp_fin >= 10'sd255)
          pack_res = {sign, 8'hFF, 23'd0};
        else if (exp_fin <= 10'sd0)
          pack_res = {sign, 31'd0};
      end
    endcase
  end

  // First of the 24 shift-add steps is folded into the capture edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      spec   <= SP_NONE;
      cnt    <= 5'd0;
      acc    <= 48'd0;
      mcand  <= 24'd0;
      sign   <= 1'b0;
      exp_r  <= 10'sd0;
      mant_r <= 23'd0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      result <= 32'd0;
      vld    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      vld <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= sel;
          if (sel) begin
            state <= CALC;
            cnt   <= 5'd0;
            sign  <= data1[31] ^ data2[31];
            exp_r <= exp_sum;
            spec  <= spec_in;
            mcand <= m1;
            acc   <= mac_step({24'd0, m2}, m1);
          end
        end
        CALC: begin
          acc <= mac_step(acc, mcand);
          cnt <= cnt + 5'd1;
          if (cnt == 5'd22)
            state <= NORM;
        end
        NORM: begin
          if (acc[47]) begin
            mant_r <= acc[46:24];
            guard  <= acc[23];
            sticky <= |acc[22:0];
            exp_r  <= exp_r + 10'sd1;
          end else begin
            mant_r <= acc[45:23];
            guard  <= acc[22];
            sticky <= |acc[21:0];
          end
          state <= PACK;
        end
        PACK: begin
          result <= pack_res;
          vld    <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
